fsm_cmd_issuer: RTL and testbench
=================================

# fsm_cmd_issuer

Command-side driver for the 3-state control FSM (IDLE→S1→S2→IDLE). It accepts 2-bit trigger commands over a valid/ready interface and buffers them in a small FIFO. It drives the FSM's `in` port one command at a time, watches the FSM's `state` output to confirm each command starts and completes, then signals `done`. Sits between the host/sequencer logic and the FSM; it is the initiating end of the FSM's `in`/`state` interface.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2
- `TIMEOUT`, 8: max cycles waited in any wait state before abort; ≥4
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_data`  in  2  command value; 2'b00 is a no-op
- `cmd_ready`  out  1  FIFO not full; reset 1
- `fsm_state`  in  2  FSM state (00 IDLE, 01 S1, 10 S2)
- `fsm_in`  out  2  registered drive to the FSM `in`; reset 00
- `busy`  out  1  issuer not in IDLE or FIFO non-empty; reset 0
- `done`  out  1  one-cycle pulse per retired command; reset 0
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy; reset 0
- `err_clr`  in  1  clears sticky error flags
- `timeout_err`  out  1  sticky; reset 0
- `illegal_err`  out  1  sticky; reset 0

## Operation
- Push when `cmd_valid && cmd_ready`. `cmd_ready = (level != DEPTH)`.
- Push and pop in the same cycle are allowed at any level, including full (ready stays 0 at full, so no push happens at full).
- Issuer states:
  - IDLE: if FIFO non-empty and `fsm_state==00`, pop the head into `cur`.
    - `cur==00`: pulse `done` and stay in IDLE. A no-op costs one cycle.
    - Otherwise: go to ISSUE, register `fsm_in<=cur`, clear the timer.
  - ISSUE: hold `fsm_in`. On sampling `fsm_state==01`, set `fsm_in<=00`, clear the timer, and go to WAIT_DONE.
  - WAIT_DONE: on sampling `fsm_state==00`, pulse `done` and go to IDLE.
- Timer counts cycles spent in ISSUE/WAIT_DONE. On reaching TIMEOUT, set `timeout_err`, force `fsm_in<=00`, go to IDLE, and do not pulse `done`. The command is dropped.
- `err_clr` clears both sticky flags. A same-cycle new error has priority over the clear.
- FIFO pointers wrap modulo DEPTH. `level` is a separate counter.

## Timing
- Command accepted at edge 0 into an empty FIFO with the FSM idle:
  - `fsm_in=cmd` after edges 1–2, returns to 00 after edge 3.
  - `done=1` for the cycle after edge 5.
  - Next pop can occur at edge 6.
- Back-to-back non-zero commands: one retirement per 5 cycles.
- `fsm_in` never stays non-zero after the edge on which S1 is sampled. This rules out a double trigger.
- Reset mid-operation: all outputs return to reset values immediately, the FIFO empties, and `cur` is discarded.

## Configuration
- `FSM_ISSUER_ILLEGAL_CHK_EN` defined:
  - Sampling `fsm_state==11` in any state sets `illegal_err`.
  - In ISSUE/WAIT_DONE it also aborts to IDLE with `fsm_in<=00` and no `done`.
- Undefined: `illegal_err` is tied 0, and 11 is treated as "not IDLE, not S1". The timeout still bounds the wait.

## Structure
- Package `fsm_pkg`: FSM state encodings (`FSM_IDLE`, `FSM_S1`, `FSM_S2`, shared with the FSM) and the issuer state typedef (IDLE/ISSUE/WAIT_DONE).
- Sub-module `cmd_fifo`: synchronous FIFO parameterized by DEPTH and width 2, with push/pop/full/empty/level.
- Issuer FSM, timer and error flags live in the top level.

## Test plan
- Single command 01 at edge 0, FSM model attached → `fsm_in` 01 after edges 1–2, `done` high after edge 5 only, `busy` low after edge 6.
- Push 4 commands (01,10,11,01) without stalling → `cmd_ready` low at `level==4`, 5th push refused; 4 `done` pulses 5 cycles apart; FIFO order preserved.
- Command 00 → `done` after edge 2, `fsm_in` stays 00 throughout.
- `fsm_state` held at 00 after issue → after TIMEOUT=8 cycles: `timeout_err=1`, `fsm_in=00`, no `done`; `err_clr` clears it next cycle.
- With the macro, force `fsm_state=11` in WAIT_DONE → `illegal_err=1`, return to IDLE, no `done`. Without the macro → only `timeout_err` after 8 cycles.
- Assert `reset` during WAIT_DONE with 2 queued → `level=0`, `fsm_in=00`, `done=0`, `busy=0` immediately; no stale command issued after release.

Source files
------------

// File: rtl/fsm_cmd_issuer_pkg.sv
// Shared encodings for the 3-state control FSM and the command issuer that drives it.
// The issuer state type and command helpers live here so the FIFO and top agree on widths.
package fsm_pkg;

  localparam int unsigned CmdW = 2;

  // FSM `state` encodings, shared with the FSM itself; 2'b11 is never legal.
  localparam logic [1:0] FSM_IDLE    = 2'b00;
  localparam logic [1:0] FSM_S1      = 2'b01;
  localparam logic [1:0] FSM_S2      = 2'b10;
  localparam logic [1:0] FSM_ILLEGAL = 2'b11;

  localparam logic [CmdW-1:0] CmdNop = 2'b00;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StIssue    = 2'b01,
    StWaitDone = 2'b10
  } issuer_state_e;

  function automatic logic is_nop(input logic [CmdW-1:0] cmd);
    return cmd == CmdNop;
  endfunction

endpackage

// File: rtl/fsm_cmd_issuer_if.sv
// Command handshake plus the FSM in/state link, bundled as one bus.
// slave is the issuer's view; master is the host/FSM side (used by the bench).
interface fsm_cmd_issuer_if;
  import fsm_pkg::*;

  logic            cmd_valid;
  logic [CmdW-1:0] cmd_data;
  logic            cmd_ready;
  logic [1:0]      fsm_state;
  logic [CmdW-1:0] fsm_in;

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  fsm_state,
    output cmd_ready,
    output fsm_in
  );

  modport master (
    output cmd_valid,
    output cmd_data,
    output fsm_state,
    input  cmd_ready,
    input  fsm_in
  );

endinterface

// File: rtl/fsm_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, occupancy kept in a separate counter.
// Push at full and pop at empty are ignored.
module cmd_fifo
  import fsm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [CmdW-1:0] wdata,
  input  logic            pop,
  output logic [CmdW-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [LvlW-1:0] level
);

  logic [CmdW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            push_ok, pop_ok;

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fsm_cmd_issuer.sv
// Command issuer: buffers 2-bit triggers and drives the control FSM one command at a time.
// Optional FSM_ISSUER_ILLEGAL_CHK_EN flags/aborts on an illegal 2'b11 FSM state.
module fsm_cmd_issuer
  import fsm_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8,
  localparam int unsigned LvlW   = $clog2(DEPTH) + 1,
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_cmd_issuer_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic [LvlW-1:0]      level,
  input  logic                 err_clr,
  output logic                 timeout_err,
  output logic                 illegal_err
);

  issuer_state_e   state_q, state_d;
  logic [CmdW-1:0] fsm_in_q, fsm_in_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            noop_q, noop_d;
  logic            timeout_err_q, timeout_err_d;
  logic            illegal_seen;
  logic            timer_expired;

  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [CmdW-1:0] head;

  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == StIdle) && !fifo_empty && (bus.fsm_state == FSM_IDLE);
  assign timer_expired = (timer_q == TimerW'(TIMEOUT - 1));

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.cmd_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

`ifdef FSM_ISSUER_ILLEGAL_CHK_EN
  logic illegal_err_q, illegal_err_d;
  assign illegal_seen = (bus.fsm_state == FSM_ILLEGAL);
  assign illegal_err  = illegal_err_q;
`else
  assign illegal_seen = 1'b0;
  assign illegal_err  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fsm_in_d      = fsm_in_q;
    timer_d       = timer_q;
    done_d        = noop_q;  // a popped no-op retires on the following cycle
    noop_d        = 1'b0;
    busy_d        = (state_q != StIdle) || !fifo_empty;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (is_nop(head)) begin
            noop_d = 1'b1;
          end else begin
            state_d  = StIssue;
            fsm_in_d = head;
            timer_d  = '0;
          end
        end
      end
      StIssue: begin
        if (illegal_seen) begin
          state_d  = StIdle;
          fsm_in_d = CmdNop;
        end else if (bus.fsm_state == FSM_S1) begin
          // Drop the trigger on the very edge S1 is seen so the FSM cannot re-fire.
          state_d  = StWaitDone;
          fsm_in_d = CmdNop;
          timer_d  = '0;
        end else if (timer_expired) begin
          state_d       = StIdle;
          fsm_in_d      = CmdNop;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (illegal_seen) begin
          state_d  = StIdle;
          fsm_in_d = CmdNop;
        end else if (bus.fsm_state == FSM_IDLE) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (timer_expired) begin
          state_d       = StIdle;
          fsm_in_d      = CmdNop;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        fsm_in_d = CmdNop;
      end
    endcase
  end

`ifdef FSM_ISSUER_ILLEGAL_CHK_EN
  always_comb begin
    illegal_err_d = err_clr ? 1'b0 : illegal_err_q;
    if (illegal_seen) illegal_err_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      fsm_in_q      <= CmdNop;
      timer_q       <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      noop_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef FSM_ISSUER_ILLEGAL_CHK_EN
      illegal_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fsm_in_q      <= fsm_in_d;
      timer_q       <= timer_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      noop_q        <= noop_d;
      timeout_err_q <= timeout_err_d;
`ifdef FSM_ISSUER_ILLEGAL_CHK_EN
      illegal_err_q <= illegal_err_d;
`endif
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.fsm_in    = fsm_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_fsm_cmd_issuer.sv
// Bench for fsm_cmd_issuer: a small FSM model, a per-cycle vector table and an issue-order
// scoreboard, plus hand-written sequences for full FIFO, timeout, illegal state and reset.
module tb_fsm_cmd_issuer;
  import fsm_pkg::*;

  localparam int unsigned LW = $clog2(4) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy, done, err_clr, timeout_err, illegal_err;
  logic [LW-1:0] level;

  logic       frc_en;
  logic [1:0] frc_val;
  logic [1:0] model_q;
  logic [1:0] prev_in;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] sb_q[$];

  typedef struct {
    logic [1:0] cmd;
    logic [6:0] in_mask;    // bit e-1: fsm_in == cmd after edge e
    logic [6:0] done_mask;  // bit e-1: done high after edge e
  } vec_t;

  vec_t vecs[4];

  fsm_cmd_issuer_if bus ();

  fsm_cmd_issuer #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .level       (level),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .illegal_err (illegal_err)
  );

  always #5 clk = ~clk;

  // Reference control FSM: any non-zero `in` in IDLE triggers IDLE->S1->S2->IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) model_q <= FSM_IDLE;
    else begin
      case (model_q)
        FSM_IDLE: if (bus.fsm_in != 2'b00) model_q <= FSM_S1;
        FSM_S1:   model_q <= FSM_S2;
        default:  model_q <= FSM_IDLE;
      endcase
    end
  end

  assign bus.fsm_state = frc_en ? frc_val : model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each new trigger must be the oldest expected non-zero command.
  always @(negedge clk) begin
    if (reset) prev_in = 2'b00;
    else begin
      if (bus.fsm_in != 2'b00 && prev_in == 2'b00) begin
        if (sb_q.size() == 0) check("sb_unexpected_issue", {30'd0, bus.fsm_in}, 32'd0);
        else check("sb_issue_order", {30'd0, bus.fsm_in}, {30'd0, sb_q.pop_front()});
      end
      prev_in = bus.fsm_in;
    end
  end

  task automatic push_cmd(input logic [1:0] cmd);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = cmd;
    if (cmd != 2'b00) sb_q.push_back(cmd);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int         done_e[$];
    logic       seen;
    logic [1:0] cmds[4];

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 2'b00;
    err_clr       = 1'b0;
    frc_en        = 1'b0;
    frc_val       = 2'b00;
    prev_in       = 2'b00;
    step();
    step();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_fsm_in", {30'd0, bus.fsm_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_illegal_err", {31'd0, illegal_err}, 32'd0);
    reset = 1'b0;
    step();

    // Single-command timing for each command value.
    vecs[0] = '{cmd: 2'b01, in_mask: 7'b0000011, done_mask: 7'b0010000};
    vecs[1] = '{cmd: 2'b10, in_mask: 7'b0000011, done_mask: 7'b0010000};
    vecs[2] = '{cmd: 2'b11, in_mask: 7'b0000011, done_mask: 7'b0010000};
    vecs[3] = '{cmd: 2'b00, in_mask: 7'b0000000, done_mask: 7'b0000010};
    for (int v = 0; v < 4; v++) begin
      push_cmd(vecs[v].cmd);  // edge 0
      for (int e = 1; e <= 7; e++) begin
        step();
        check($sformatf("vec%0d_fsm_in_e%0d", v, e), {30'd0, bus.fsm_in},
              vecs[v].in_mask[e-1] ? {30'd0, vecs[v].cmd} : 32'd0);
        check($sformatf("vec%0d_done_e%0d", v, e), {31'd0, done},
              {31'd0, vecs[v].done_mask[e-1]});
        if (e == 6) check($sformatf("vec%0d_busy_e6", v), {31'd0, busy}, 32'd0);
      end
      step();
    end

    // Fill the FIFO while the FSM looks busy, refuse a 5th push, then drain in order.
    frc_en  = 1'b1;
    frc_val = FSM_S2;
    cmds[0] = 2'b01;
    cmds[1] = 2'b10;
    cmds[2] = 2'b11;
    cmds[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push_cmd(cmds[i]);
      check($sformatf("fill_level_%0d", i), {29'd0, level}, i + 1);
    end
    check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 2'b10;
    step();  // edge 4: refused
    bus.cmd_valid = 1'b0;
    check("full_refused_level", {29'd0, level}, 32'd4);
    frc_en = 1'b0;
    step();  // edge 5: first pop
    check("drain_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    for (int e = 6; e <= 34; e++) begin
      step();
      if (done) done_e.push_back(e);
    end
    check("drain_done_count", done_e.size(), 32'd4);
    if (done_e.size() == 4) begin
      check("drain_first_done", done_e[0], 32'd9);
      for (int i = 1; i < 4; i++)
        check($sformatf("drain_done_gap_%0d", i), done_e[i] - done_e[i-1], 32'd5);
    end

    // FSM never leaves IDLE: ISSUE times out after 8 cycles, no done.
    frc_en  = 1'b1;
    frc_val = FSM_IDLE;
    seen    = 1'b0;
    push_cmd(2'b01);  // edge 0
    for (int e = 1; e <= 8; e++) begin
      step();
      seen |= done;
    end
    check("to_err_before", {31'd0, timeout_err}, 32'd0);
    step();  // edge 9
    seen |= done;
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    check("to_fsm_in", {30'd0, bus.fsm_in}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    seen |= done;
    check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
    check("to_no_done", {31'd0, seen}, 32'd0);
    frc_en = 1'b0;
    for (int e = 0; e < 4; e++) step();

    // Illegal FSM state while waiting for completion.
    seen = 1'b0;
    push_cmd(2'b10);  // edge 0
    step();
    step();
    step();  // edge 3: now in WAIT_DONE
    frc_en  = 1'b1;
    frc_val = FSM_ILLEGAL;
`ifdef FSM_ISSUER_ILLEGAL_CHK_EN
    step();  // edge 4
    seen |= done;
    check("ill_err_set", {31'd0, illegal_err}, 32'd1);
    check("ill_fsm_in", {30'd0, bus.fsm_in}, 32'd0);
    check("ill_no_timeout", {31'd0, timeout_err}, 32'd0);
    frc_en = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      seen |= done;
    end
    check("ill_no_done", {31'd0, seen}, 32'd0);
    check("ill_idle_busy", {31'd0, busy}, 32'd0);
`else
    for (int e = 4; e <= 10; e++) begin
      step();
      seen |= done;
    end
    check("ill_to_before", {31'd0, timeout_err}, 32'd0);
    step();  // edge 11
    seen |= done;
    check("ill_to_set", {31'd0, timeout_err}, 32'd1);
    check("ill_err_tied", {31'd0, illegal_err}, 32'd0);
    check("ill_no_done", {31'd0, seen}, 32'd0);
    frc_en = 1'b0;
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ill_clr_timeout", {31'd0, timeout_err}, 32'd0);
    check("ill_clr_illegal", {31'd0, illegal_err}, 32'd0);
    for (int e = 0; e < 4; e++) step();

    // Reset during WAIT_DONE with two commands still queued.
    push_cmd(2'b01);  // edge 0
    push_cmd(2'b10);  // edge 1: first pops
    push_cmd(2'b11);  // edge 2
    step();           // edge 3: WAIT_DONE
    check("rstmid_level_before", {29'd0, level}, 32'd2);
    reset = 1'b1;
    #1;
    sb_q.delete();
    check("rstmid_level", {29'd0, level}, 32'd0);
    check("rstmid_fsm_in", {30'd0, bus.fsm_in}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b0;
    seen  = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      seen |= (bus.fsm_in != 2'b00) || done;
    end
    check("rstmid_no_stale", {31'd0, seen}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
